// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console transmitter.
// TXDATA (BASE_ADDR) stores push a byte into a small FIFO; STATUS
// (BASE_ADDR+4) reports full/empty/active/overflow/count and lets the core
// clear the sticky overflow flag. Bytes leave on tx as 8N1 frames.
// Optional feature: define UART_PARITY_EN to insert an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
`ifdef UART_PARITY_EN
  logic            par_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic hit_tx, hit_st, full, empty, push, pop, baud_last;

  assign hit_tx    = (addr == BASE_ADDR);
  assign hit_st    = (addr == STATUS_ADDR);
  assign full      = (count_q == CNTW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  // Fullness is taken from the registered count, so a push on a full FIFO
  // is dropped even if the transmitter pops on the same edge.
  assign push      = we && hit_tx && !full;
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign sel  = hit_tx || hit_st;
  assign tx   = tx_q;
  assign busy = !empty || (state_q != ST_IDLE);

  // Only the low byte and the ovf-clear bit of store data matter.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // STATUS read mux; everything else (including TXDATA reads) returns 0.
  always_comb begin
    rdata = '0;
    if (re && hit_st) begin
      rdata[0]         = full;
      rdata[1]         = empty;
      rdata[2]         = (state_q != ST_IDLE);
      rdata[3]         = ovf_q;
      rdata[7 +: CNTW] = count_q;
    end
  end

  // FIFO pointer/count/overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (we && hit_st && wdata[3]) ovf_d = 1'b0;
    if (we && hit_tx && full)     ovf_d = 1'b1;
  end

  // FIFO control registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  // Transmit FSM with registered serial output.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!empty) begin
            shift_q <= mem_q[rd_ptr_q];
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
`ifdef UART_PARITY_EN
            par_q   <= ^mem_q[rd_ptr_q];
`endif
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: randomized bus traffic against a queue-based
// reference model; a UART receiver process decodes tx and checks each frame
// against a scoreboard of expected bytes and start edges.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .sel(sel), .tx(tx), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int edge_no = 0;
  always @(posedge CLK) edge_no <= edge_no + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: queued bytes, cycles left in the current frame, ovf.
  logic [7:0] mq[$];
  int         rem = 0;
  bit         movf = 1'b0;
  int         rst_cnt = 0;

  // Scoreboard: byte and the edge on which its start bit should begin.
  logic [7:0] exp_q[$];
  int         exp_edge_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic logic [31:0] model_rdata();
    int s;
    s = mq.size();
    if (!re || addr != BASE + 32'd4) return 32'h0;
    return 32'(((s == DEPTH) ? 1 : 0) + ((s == 0) ? 2 : 0) + ((rem > 0) ? 4 : 0)
               + (movf ? 8 : 0) + s * 128);
  endfunction

  // Check outputs for the current cycle, then advance model and DUT one edge.
  task automatic step();
    int pre;
    #1;
    if (!reset) begin
      chk("busy", busy, (mq.size() > 0 || rem > 0) ? 1 : 0);
      if (rem == 0) chk("tx_idle", tx, 1);
      chk("sel", sel, (addr == BASE || addr == BASE + 32'd4) ? 1 : 0);
      if (re) chk("rdata", rdata, model_rdata());
    end
    if (reset) begin
      mq.delete();
      rem = 0;
      movf = 1'b0;
      rst_cnt++;
    end else begin
      pre = mq.size();
      if (rem > 0) rem--;
      else if (pre > 0) begin
        exp_q.push_back(mq.pop_front());
        exp_edge_q.push_back(edge_no + 1);
        rem = FRAME_CYC;
      end
      if (we && addr == BASE) begin
        if (pre < DEPTH) mq.push_back(wdata[7:0]);
        else movf = 1'b1;
      end
      if (we && addr == BASE + 32'd4 && wdata[3]) movf = 1'b0;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    re = 1'b1; addr = a;
    step();
    re = 1'b0; addr = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && (mq.size() > 0 || rem > 0); i++) step();
    idle(3);
  endtask

  // Monitor: UART receiver sampling mid-bit, compares against the scoreboard.
  initial begin : monitor
    logic prev;
    logic [FRAME_BITS-1:0] bits;
    logic [7:0] eb;
    int ee, se, r0, off;
    bit aborted, have;
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (prev === 1'b1 && tx === 1'b0) begin
        se = edge_no;
        r0 = rst_cnt;
        have = (exp_q.size() > 0);
        if (!have) begin
          errors++;
          checks++;
          $display("FAIL unexpected_frame: start seen at edge %0d expected none", se);
          eb = 8'h0; ee = 0;
        end else begin
          eb = exp_q.pop_front();
          ee = exp_edge_q.pop_front();
        end
        aborted = 1'b0;
        off = 0;
        bits = '0;
        for (int k = 0; k < FRAME_BITS && !aborted; k++) begin
          while (off < k * CPB + CPB / 2 && !aborted) begin
            @(negedge CLK);
            off++;
            if (rst_cnt != r0) aborted = 1'b1;
          end
          if (!aborted) bits[k] = tx;
        end
        if (!aborted && have) begin
          chk("frame_start_edge", se, ee);
          chk("frame_start_bit", bits[0], 0);
          chk("frame_byte", bits[8:1], eb);
`ifdef UART_PARITY_EN
          chk("frame_parity", bits[9], ^eb);
`endif
          chk("frame_stop_bit", bits[FRAME_BITS-1], 1);
        end
        prev = tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : stim
    int op;
    @(negedge CLK);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Reset state
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    bus_read(BASE + 32'd4);

    // Single byte 0x41
    bus_write(BASE, 32'h0000_0041);
    drain();

    // TXDATA read returns 0 with sel high; unrelated address deselects
    bus_read(BASE);
    bus_read(BASE + 32'd8);

    // Overflow: six back-to-back writes while idle
    for (int i = 0; i < 6; i++) bus_write(BASE, 32'h31 + 32'(i));
    bus_read(BASE + 32'd4);
    bus_write(BASE + 32'd4, 32'h8);
    bus_read(BASE + 32'd4);
    drain();

    // Back-to-back drain of three bytes
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'hFF);
    drain();

`ifdef UART_PARITY_EN
    bus_write(BASE, 32'h43);
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) bus_write(BASE, $urandom);
      else if (op == 5) bus_read(BASE + 32'd4);
      else if (op == 6) bus_write(BASE + 32'd8, $urandom);
      else if (op == 7) bus_write(BASE + 32'd4, $urandom);
      else if (op == 8) bus_read($urandom_range(0, 1) ? BASE : BASE - 32'd4);
      else idle($urandom_range(1, 30));
    end
    drain();

    // Reset during DATA bit 3 with a second byte still queued
    bus_write(BASE, 32'h5A);
    bus_write(BASE, 32'h77);
    for (int i = 0; i < 200 && rem != FRAME_CYC - 4 * CPB - 2; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_tx", tx, 1);
    bus_read(BASE + 32'd4);
    idle(3 * FRAME_CYC);

    chk("frames_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
